// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the sequencer and the ALU instantiation site.
package alu_pkg;

    localparam int unsigned alu_op_width_lp = 2;

    typedef enum logic [alu_op_width_lp-1:0] {
        e_and  = 2'b00,
        e_xor  = 2'b01,
        e_nand = 2'b10,
        e_add  = 2'b11
    } e_alu_op;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command front end for the 4-function ALU: registers one command, drives the ALU,
// captures its result into the output and accumulator registers, and counts consumed results.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned width_p       = 8,
    parameter int unsigned count_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [alu_op_width_lp-1:0] op_i,
    input  logic                       acc_i,
    input  logic [width_p-1:0]         a_i,
    input  logic [width_p-1:0]         b_i,

    output logic [alu_op_width_lp-1:0] alu_sel_o,
    output logic [width_p-1:0]         alu_a_o,
    output logic [width_p-1:0]         alu_b_o,
    input  logic [width_p-1:0]         alu_res_i,

    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [width_p-1:0]         acc_o,
    output logic [count_width_p-1:0]   count_o
);

    typedef enum logic [1:0] {
        e_idle,
        e_issue,
        e_result
    } state_e;

    typedef struct packed {
        e_alu_op            op;
        logic [width_p-1:0] a;
        logic [width_p-1:0] b;
    } alu_cmd_s;

    state_e   state;
    alu_cmd_s cmd;

    // ALU inputs come only from the command register, never straight from the command port.
    assign alu_sel_o = cmd.op;
    assign alu_a_o   = cmd.a;
    assign alu_b_o   = cmd.b;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= e_idle;
            cmd     <= '0;
            ready_o <= 1'b1;
            v_o     <= 1'b0;
            data_o  <= '0;
            acc_o   <= '0;
            count_o <= '0;
        end else begin
            case (state)
                e_idle: begin
                    if (v_i) begin
                        cmd.op  <= e_alu_op'(op_i);
                        cmd.a   <= acc_i ? acc_o : a_i;
                        cmd.b   <= b_i;
                        ready_o <= 1'b0;
                        state   <= e_issue;
                    end
                end
                e_issue: begin
                    data_o <= alu_res_i;
                    acc_o  <= alu_res_i;
                    v_o    <= 1'b1;
                    state  <= e_result;
                end
                e_result: begin
                    if (yumi_i) begin
                        count_o <= count_o + count_width_p'(1);
                        v_o     <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= e_idle;
                    end
                end
                default: begin
                    v_o     <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= e_idle;
                end
            endcase
        end
    end

    // Consuming a result that is not being offered is a downstream protocol violation.
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU and reference model.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset_i;
    logic          v_i;
    logic          ready_o;
    logic [1:0]    op_i;
    logic          acc_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [1:0]    alu_sel_o;
    logic [W-1:0]  alu_a_o;
    logic [W-1:0]  alu_b_o;
    logic [W-1:0]  alu_res_i;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic [W-1:0]  acc_o;
    logic [CW-1:0] count_o;

    int n_checks = 0;
    int n_errors = 0;
    int m_acc    = 0;
    int m_count  = 0;

    alu_op_sequencer #(.width_p(W), .count_width_p(CW)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .acc_i     (acc_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .alu_sel_o (alu_sel_o),
        .alu_a_o   (alu_a_o),
        .alu_b_o   (alu_b_o),
        .alu_res_i (alu_res_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .acc_o     (acc_o),
        .count_o   (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic on plain integers: 0 AND, 1 XOR, 2 NAND, 3 ADD (mod 256).
    function automatic int alu_ref(int op, int a, int b);
        case (op)
            0:       return a & b;
            1:       return a ^ b;
            2:       return 255 - (a & b);
            default: return (a + b) % 256;
        endcase
    endfunction

    // Combinational ALU stand-in driven by the sequencer.
    always_comb alu_res_i = W'(alu_ref(int'(alu_sel_o), int'(alu_a_o), int'(alu_b_o)));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        m_acc   = 0;
        m_count = 0;
    endtask

    // One full operation; hold = RESULT cycles without yumi, noise = junk v_i during hold,
    // abort = reset while in RESULT instead of consuming.
    task automatic run_op(input int op, input bit use_acc, input int a, input int b,
                          input int hold, input bit noise, input bit abort);
        int opa;
        int res;
        @(negedge clk);
        check("ready_idle", 32'(ready_o), 32'd1);
        opa   = use_acc ? m_acc : a;
        res   = alu_ref(op, opa, b);
        v_i   = 1'b1;
        op_i  = 2'(op);
        acc_i = use_acc;
        a_i   = W'(a);
        b_i   = W'(b);
        @(negedge clk);
        v_i = 1'b0;
        a_i = W'($urandom);
        b_i = W'($urandom);
        check("issue_v", 32'(v_o), 32'd0);
        check("issue_ready", 32'(ready_o), 32'd0);
        check("issue_sel", 32'(alu_sel_o), 32'(op));
        check("issue_a", 32'(alu_a_o), 32'(opa));
        check("issue_b", 32'(alu_b_o), 32'(b));
        @(negedge clk);
        m_acc = res;
        check("res_v", 32'(v_o), 32'd1);
        check("res_data", 32'(data_o), 32'(res));
        check("res_acc", 32'(acc_o), 32'(res));
        check("res_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                v_i   = 1'b1;
                op_i  = 2'($urandom);
                acc_i = 1'($urandom);
                a_i   = W'($urandom);
                b_i   = W'($urandom);
            end
            @(negedge clk);
            v_i = 1'b0;
            check("hold_v", 32'(v_o), 32'd1);
            check("hold_data", 32'(data_o), 32'(res));
            check("hold_acc", 32'(acc_o), 32'(res));
            check("hold_count", 32'(count_o), 32'(m_count));
            check("hold_ready", 32'(ready_o), 32'd0);
        end
        if (abort) begin
            reset_i = 1'b1;
            @(negedge clk);
            reset_i = 1'b0;
            m_acc   = 0;
            m_count = 0;
            check("abort_v", 32'(v_o), 32'd0);
            check("abort_acc", 32'(acc_o), 32'd0);
            check("abort_count", 32'(count_o), 32'd0);
            check("abort_ready", 32'(ready_o), 32'd1);
            return;
        end
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i  = 1'b0;
        m_count = (m_count + 1) % 65536;
        check("done_count", 32'(count_o), 32'(m_count));
        check("done_v", 32'(v_o), 32'd0);
        check("done_ready", 32'(ready_o), 32'd1);
        check("done_acc", 32'(acc_o), 32'(m_acc));
    endtask

    // Streaming run: v_i held high, yumi follows v_o, results must come back in issue order every 3 cycles.
    task automatic back_to_back(input int n_ops);
        int exp_q[$];
        int issued  = 0;
        int done    = 0;
        int last_c  = -1;
        int opa;
        int op;
        bit ua;
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && done < n_ops; cyc++) begin
            if (v_o) begin
                check("b2b_data", 32'(data_o), 32'(exp_q.pop_front()));
                if (last_c >= 0) check("b2b_gap", 32'(cyc - last_c), 32'd3);
                last_c = cyc;
                done++;
                m_count = (m_count + 1) % 65536;
            end
            yumi_i = v_o;
            if (ready_o) begin
                if (issued < n_ops) begin
                    op    = int'($urandom_range(3));
                    ua    = 1'($urandom);
                    v_i   = 1'b1;
                    op_i  = 2'(op);
                    acc_i = ua;
                    a_i   = W'($urandom);
                    b_i   = W'($urandom);
                    opa   = ua ? m_acc : int'(a_i);
                    m_acc = alu_ref(op, opa, int'(b_i));
                    exp_q.push_back(m_acc);
                    issued++;
                end else begin
                    v_i = 1'b0;
                end
            end
            @(negedge clk);
        end
        v_i    = 1'b0;
        yumi_i = 1'b0;
        check("b2b_done", 32'(done), 32'(n_ops));
        check("b2b_count", 32'(count_o), 32'(m_count));
        check("b2b_acc", 32'(acc_o), 32'(m_acc));
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        op_i    = '0;
        acc_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        yumi_i  = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_v", 32'(v_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_acc", 32'(acc_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_sel", 32'(alu_sel_o), 32'd0);
        check("rst_alu_a", 32'(alu_a_o), 32'd0);
        check("rst_alu_b", 32'(alu_b_o), 32'd0);

        run_op(3, 1'b0, 3, 4, 0, 1'b0, 1'b0);
        run_op(3, 1'b0, 8'hF0, 8'h0A, 0, 1'b0, 1'b0);
        run_op(3, 1'b1, 0, 8'h0A, 0, 1'b0, 1'b0);
        run_op(2, 1'b0, 8'hF0, 8'hFF, 0, 1'b0, 1'b0);
        run_op(1, 1'b0, 8'hAA, 8'h55, 0, 1'b0, 1'b0);
        run_op(0, 1'b0, 8'hAA, 8'h0F, 0, 1'b0, 1'b0);
        run_op(1, 1'b1, 0, 8'h3C, 5, 1'b1, 1'b0);
        run_op(3, 1'b0, 8'h80, 8'h80, 1, 1'b1, 1'b1);
        run_op(3, 1'b0, 1, 1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(3)), 1'($urandom), int'($urandom_range(255)),
                   int'($urandom_range(255)), int'($urandom_range(3)), 1'($urandom), 1'b0);
        end

        back_to_back(4);
        do_reset();
        check("final_count", 32'(count_o), 32'd0);
        back_to_back(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
